// File: rtl/ic1337_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ic1337_bist_pkg
// Brief    : Shared state encoding and MISR constants for the ic1337 BIST.
// Revision : 1.0  initial release
// ============================================================================
package ic1337_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] c_misr_seed = 8'hFF;
    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] c_misr_taps = 8'b1011_1000;

    function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic [2:0] din);
        return {sig[6:0], ^(sig & c_misr_taps)} ^ {5'b0_0000, din};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic1337_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : ic1337_bist_if
// Brief    : Control, stimulus and response bundle between BIST and its user.
// Revision : 1.0  initial release
// ============================================================================
interface ic1337_bist_if;

    logic       start;
    logic       abort;
    logic       q0;
    logic       q1;
    logic       z;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;

    modport slave (
        input  start, abort, q0, q1, z,
        output a0, a1, a2, busy, done, pass, signature
    );

    modport master (
        output start, abort, q0, q1, z,
        input  a0, a1, a2, busy, done, pass, signature
    );

endinterface
`default_nettype wire

// File: rtl/ic1337_bist_misr8.sv
`default_nettype none
// ============================================================================
// Module   : misr8
// Brief    : 8-bit multiple-input signature register compacting 3 response bits.
// Revision : 1.0  initial release
// ============================================================================
module misr8
    import ic1337_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic [2:0] din,
    output logic [7:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 8'h00;
        end else if (init) begin
            sig <= c_misr_seed;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ic1337_bist.sv
`default_nettype none
// ============================================================================
// Module   : ic1337_bist
// Brief    : Sequences stimulus into the ic1337, compacts responses, compares.
// Revision : 1.0  initial release
// ============================================================================
module ic1337_bist
    import ic1337_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned SETTLE      = 1,
    parameter logic [7:0]  EXP_SIG     = 8'hFE
) (
    input  logic          clk,
    input  logic          rst_n,
    ic1337_bist_if.slave  bus
);

    localparam logic [7:0] c_idx_last    = 8'(NUM_VECTORS - 1);
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] w_idx_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_pass;
    logic       w_pass_nxt;
    logic       w_misr_init;
    logic       w_misr_en;
    logic [7:0] w_sig;
    logic       w_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 8'd0;
            r_cnt   <= 4'd0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Abort is tested first in every state so it outranks all other moves.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        w_misr_init = 1'b0;
        w_misr_en   = 1'b0;

        if (bus.abort && (r_state != ST_IDLE || r_pass)) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 8'd0;
            w_cnt_nxt   = 4'd0;
            w_pass_nxt  = 1'b0;
        end else if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_APPLY;
                        w_idx_nxt   = 8'd0;
                        w_cnt_nxt   = 4'd0;
                        w_pass_nxt  = 1'b0;
                        w_misr_init = 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (r_cnt == c_settle_last) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    w_misr_en = 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_APPLY;
                        w_idx_nxt   = r_idx + 8'd1;
                    end
                end
                ST_CHECK: begin
                    w_pass_nxt  = (w_sig == EXP_SIG);
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    misr8 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_misr_init),
        .en    (w_misr_en),
        .din   ({bus.z, bus.q1, bus.q0}),
        .sig   (w_sig)
    );

    assign w_drive       = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign bus.a0        = w_drive & r_idx[0];
    assign bus.a1        = w_drive & r_idx[1];
    assign bus.a2        = w_drive & r_idx[2];
    assign bus.busy      = w_drive || (r_state == ST_CHECK);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.pass      = (r_state == ST_DONE) & r_pass;
    assign bus.signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_ic1337_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic1337_bist
// Brief    : Directed self-checking bench for ic1337_bist (default and 1-vector).
// Revision : 1.0  initial release
// ============================================================================
module tb_ic1337_bist;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ic1337_bist_if bus_a ();
    ic1337_bist_if bus_b ();

    ic1337_bist u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ic1337_bist #(
        .NUM_VECTORS (1),
        .SETTLE      (1),
        .EXP_SIG     (8'hFE)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int limit, output int cyc);
        cyc = 0;
        while (!bus_a.done && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [2:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {5'b0, d};
    endfunction

    function automatic logic [2:0] a_of_a();
        return {bus_a.a2, bus_a.a1, bus_a.a0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic [7:0] model;

        {bus_a.start, bus_a.abort, bus_a.q0, bus_a.q1, bus_a.z} = '0;
        {bus_b.start, bus_b.abort, bus_b.q0, bus_b.q1, bus_b.z} = '0;

        repeat (2) tick();
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_pass", bus_a.pass, 0);
        chk("rst_sig", bus_a.signature, 8'h00);
        chk("rst_a", a_of_a(), 0);
        chk("rst_sig_b", bus_b.signature, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_busy", bus_a.busy, 0);

        // One-vector instance: done three edges after start, seed step gives FE
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        cyc = 0;
        while (!bus_b.done && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("b_latency", cyc, 3);
        chk("b_sig", bus_b.signature, 8'hFE);
        chk("b_pass", bus_b.pass, 1);
        tick();
        chk("b_done_hold", bus_b.done, 1);

        // Default run with q0=1: every step maps FF back to FF
        bus_a.q0 = 1'b1;
        pulse_start_a();
        for (int j = 0; j < 32; j++) begin
            chk("seq_a", a_of_a(), 32'((j / 2) % 8));
            tick();
        end
        chk("seq_done_early", bus_a.done, 0);
        chk("seq_check_busy", bus_a.busy, 1);
        chk("seq_check_a", a_of_a(), 0);
        tick();
        chk("seq_done", bus_a.done, 1);
        chk("seq_sig", bus_a.signature, 8'hFF);
        chk("seq_pass", bus_a.pass, 0);
        bus_a.q0 = 1'b0;

        // Abort and start together in DONE: abort wins
        bus_a.abort = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        bus_a.start = 1'b0;
        chk("abrt_done_done", bus_a.done, 0);
        chk("abrt_done_busy", bus_a.busy, 0);
        chk("abrt_done_pass", bus_a.pass, 0);

        // Abort while sampling vector 5; MISR keeps FE,FC,F8,F0,E1 history
        pulse_start_a();
        repeat (11) tick();
        chk("abrt_pre_a", a_of_a(), 5);
        chk("abrt_pre_busy", bus_a.busy, 1);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        chk("abrt_busy", bus_a.busy, 0);
        chk("abrt_done", bus_a.done, 0);
        chk("abrt_a", a_of_a(), 0);
        chk("abrt_sig", bus_a.signature, 8'hE1);
        repeat (3) tick();
        chk("abrt_idle", bus_a.busy, 0);

        // Fresh all-zero run after abort must reach the fault-free C6
        pulse_start_a();
        chk("rerun_seed", bus_a.signature, 8'hFF);
        wait_done_a(100, cyc);
        chk("rerun_latency", cyc, 33);
        chk("rerun_sig", bus_a.signature, 8'hC6);
        chk("rerun_pass", bus_a.pass, 0);

        // Start held high: no restart while busy, restart right after DONE
        bus_a.start = 1'b1;
        tick();
        repeat (20) tick();
        chk("hold_a", a_of_a(), 2);
        chk("hold_busy", bus_a.busy, 1);
        repeat (13) tick();
        chk("hold_done", bus_a.done, 1);
        chk("hold_done_busy", bus_a.busy, 0);
        tick();
        chk("hold_restart_busy", bus_a.busy, 1);
        chk("hold_restart_done", bus_a.done, 0);
        chk("hold_restart_sig", bus_a.signature, 8'hFF);
        chk("hold_restart_a", a_of_a(), 0);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;

        // Asynchronous reset between edges while sampling vector 3
        pulse_start_a();
        repeat (7) tick();
        chk("rstm_pre_a", a_of_a(), 3);
        chk("rstm_pre_sig", bus_a.signature, 8'hF8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_busy", bus_a.busy, 0);
        chk("rstm_done", bus_a.done, 0);
        chk("rstm_pass", bus_a.pass, 0);
        chk("rstm_a", a_of_a(), 0);
        chk("rstm_sig", bus_a.signature, 8'h00);
        #10;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rstm_wait_busy", bus_a.busy, 0);
        chk("rstm_wait_done", bus_a.done, 0);

        // z stuck at 1 from vector 3 onward
        pulse_start_a();
        repeat (6) tick();
        bus_a.z = 1'b1;
        wait_done_a(100, cyc);
        chk("zf_latency", 6 + cyc, 33);
        model = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            model = misr_step(model, (i >= 3) ? 3'b100 : 3'b000);
        end
        chk("zf_sig", bus_a.signature, model);
        chk("zf_sig_differs", (bus_a.signature != 8'hC6), 1);
        chk("zf_pass", bus_a.pass, 0);
        chk("zf_done", bus_a.done, 1);
        bus_a.z = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ic1337_bist.md
IC1337_BIST -- requirements
Module: ic1337_bist

Interface
REQ-001 The block SHALL take parameter NUM_VECTORS, default 16, the number of stimulus vectors per run (legal range 1..256).
REQ-002 The block SHALL take parameter SETTLE, default 1, the number of cycles each vector is held before its response is sampled (legal range 1..15).
REQ-003 The block SHALL take parameter EXP_SIG, default 8'hFE, the golden 8-bit response signature.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  run request; sampled in IDLE and DONE only.
REQ-007 abort  input  1  synchronous abort of a run in progress.
REQ-008 q0, q1, z  input  1 each  responses from the ic1337 under test.
REQ-009 a0, a1, a2  output  1 each  stimulus to the ic1337 A0/A1/A2 inputs.
REQ-010 busy  output  1  high while in APPLY, SAMPLE or CHECK.
REQ-011 done  output  1  high in DONE; held until the next start, abort or reset.
REQ-012 pass  output  1  signature-compare result; valid only while done=1, else 0.
REQ-013 signature  output  8  current MISR contents.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, APPLY, SAMPLE, CHECK and DONE.
REQ-015 IDLE/DONE with start=1 -> APPLY: vector index idx <= 0, settle counter <= 0, MISR <= 8'hFF, done <= 0, pass <= 0.
REQ-016 In APPLY the block SHALL drive {a2,a1,a0} = idx[2:0] and hold it for exactly SETTLE cycles, then move to SAMPLE.
REQ-017 In SAMPLE, one cycle: {a2,a1,a0} held, MISR <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {5'b0, z, q1, q0}, using q0/q1/z as sampled at that edge.
REQ-018 SAMPLE -> APPLY with idx+1 if idx < NUM_VECTORS-1; otherwise SAMPLE -> CHECK.
REQ-019 In CHECK, one cycle: pass <= (MISR == EXP_SIG); then -> DONE.
REQ-020 done SHALL first be high exactly NUM_VECTORS*(SETTLE+1)+1 cycles after the edge that accepted start.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 abort=1 in APPLY/SAMPLE/CHECK SHALL force IDLE next edge: done=0, pass=0, stimulus 0, MISR retains its value; abort takes priority over every other transition.
REQ-023 abort in IDLE or DONE SHALL force IDLE and clear done/pass; if start and abort are both high, abort wins.
REQ-024 Outside APPLY/SAMPLE, {a2,a1,a0} SHALL be 3'b000.
REQ-025 idx above 7 SHALL wrap the stimulus (idx[2:0]); idx itself SHALL count to NUM_VECTORS-1 without overflow.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, idx=0, settle count=0, signature=8'h00, a0=a1=a2=0, busy=0, done=0, pass=0, independent of clk.
REQ-027 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Structure
REQ-028 Package ic1337_bist_pkg SHALL hold the state encoding, the MISR seed 8'hFF and the feedback tap constant.
REQ-029 The MISR SHALL be a sub-module misr8 (clk, rst_n, init, en, din[2:0], sig[7:0]); the FSM, counters and compare SHALL stay in ic1337_bist.

Verification
REQ-030 NUM_VECTORS=1, SETTLE=1, q0=q1=z=0, pulse start -> done high 3 cycles after the start edge, signature=8'hFE, pass=1.
REQ-031 Defaults, q0=1, q1=z=0 -> a-sequence 0,1,...,7,0,...,7, each value held 2 cycles; done 33 cycles after start; signature equals the value from the bench MISR model; pass=(model==8'hFE).
REQ-032 Abort pulsed during idx=5 -> IDLE next edge, busy=0, done=0, a=000; a new start gives a full run and a fresh MISR seed.
REQ-033 start held high through a run -> no restart while busy; new run starts the cycle after DONE is entered.
REQ-034 rst_n dropped between clock edges mid-SAMPLE -> all outputs reach reset values before the next edge.
REQ-035 z stuck at 1 from vector 3 onward -> signature differs from the fault-free value, pass=0, done=1.
